// File: rtl/score_keeper.sv
// Two-digit packed-BCD score counter (00..99) with saturating increment/decrement
// strobes, a synchronous score clear and an asynchronous active-low system reset.
module score_keeper (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstScore,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] currScore
);

    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tens_next;
    logic [3:0] ones_next;

    logic at_max;
    logic at_min;
    logic do_inc;
    logic do_dec;

    assign at_max = (tens == 4'd9) && (ones == 4'd9);
    assign at_min = (tens == 4'd0) && (ones == 4'd0);

    // Simultaneous strobes cancel; each direction saturates at its end of the range.
    assign do_inc = inc && !dec && !at_max;
    assign do_dec = dec && !inc && !at_min;

    always_comb begin
        tens_next = tens;
        ones_next = ones;
        if (rstScore) begin
            tens_next = 4'd0;
            ones_next = 4'd0;
        end else if (do_inc) begin
            if (ones != 4'd9) begin
                ones_next = ones + 4'd1;
            end else begin
                ones_next = 4'd0;
                tens_next = tens + 4'd1;
            end
        end else if (do_dec) begin
            if (ones != 4'd0) begin
                ones_next = ones - 4'd1;
            end else begin
                ones_next = 4'd9;
                tens_next = tens - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else begin
            tens <= tens_next;
            ones <= ones_next;
        end
    end

    assign currScore = {tens, ones};

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: reset behaviour, BCD carry/borrow, saturation,
// cancelling strobes, score clear and held strobes.
module tb_score_keeper;

    logic       clk_tb;
    logic       rst;
    logic       rst_score;
    logic       inc;
    logic       dec;
    logic [7:0] curr_score;

    int checks;
    int failures;

    score_keeper dut (
        .clk      (clk_tb),
        .rst      (rst),
        .rstScore (rst_score),
        .inc      (inc),
        .dec      (dec),
        .currScore(curr_score)
    );

    // Clock and reset defaults
    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    // Drive inputs on the falling edge, then sample just after the next rising edge.
    task automatic drive(input logic i, input logic d, input logic s);
        @(negedge clk_tb);
        inc       = i;
        dec       = d;
        rst_score = s;
        @(posedge clk_tb);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_digits(input string tag);
        check_val({tag, "_tens"}, {7'd0, curr_score[7:4] <= 4'd9}, 8'd1);
        check_val({tag, "_ones"}, {7'd0, curr_score[3:0] <= 4'd9}, 8'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        rst_score = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;

        // Reset held for two cycles, then released
        #1;
        check_val("reset_async", curr_score, 8'h00);
        drive(1'b1, 1'b0, 1'b0);
        check_val("reset_hold1", curr_score, 8'h00);
        drive(1'b1, 1'b0, 1'b0);
        check_val("reset_hold2", curr_score, 8'h00);
        @(negedge clk_tb);
        inc = 1'b0;
        rst = 1'b1;
        idle();
        check_val("reset_release", curr_score, 8'h00);

        // Eleven single-cycle inc pulses, two idle cycles each
        for (int k = 1; k <= 11; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            check_val($sformatf("inc_%0d", k), curr_score, to_bcd(k));
            idle();
            idle();
            check_val($sformatf("inc_hold_%0d", k), curr_score, to_bcd(k));
        end

        // Twelve dec pulses from 11, last one saturates at 00
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            check_val($sformatf("dec_%0d", k), curr_score, to_bcd((11 - k) < 0 ? 0 : (11 - k)));
            idle();
        end

        // Async reset mid-count: clears without a clock edge, and eats a held strobe
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0);
        idle();
        check_val("pre_async", curr_score, 8'h03);
        @(negedge clk_tb);
        inc = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_val("async_clear", curr_score, 8'h00);
        @(posedge clk_tb);
        #1;
        check_val("async_strobe_dropped", curr_score, 8'h00);
        @(negedge clk_tb);
        inc = 1'b0;
        rst = 1'b1;
        idle();
        check_val("async_release", curr_score, 8'h00);

        // Preload to 99 with a held inc, then saturate and step down
        for (int k = 0; k < 99; k++) drive(1'b1, 1'b0, 1'b0);
        idle();
        check_val("preload_99", curr_score, 8'h99);
        drive(1'b1, 1'b0, 1'b0);
        check_val("sat_99", curr_score, 8'h99);
        check_digits("sat_99");
        idle();
        drive(1'b0, 1'b1, 1'b0);
        check_val("dec_from_99", curr_score, 8'h98);

        // Score clear held for two edges
        drive(1'b0, 1'b0, 1'b1);
        check_val("clear_1", curr_score, 8'h00);
        drive(1'b1, 1'b0, 1'b1);
        check_val("clear_2_with_inc", curr_score, 8'h00);

        // Cancelling strobes at 05, then clear beats inc
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b0);
        idle();
        check_val("preload_05", curr_score, 8'h05);
        drive(1'b1, 1'b1, 1'b0);
        check_val("inc_dec_cancel", curr_score, 8'h05);
        drive(1'b1, 1'b0, 1'b1);
        check_val("clear_beats_inc", curr_score, 8'h00);
        idle();
        check_val("clear_then_idle", curr_score, 8'h00);

        // Held inc from 08 across the digit carry
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b0);
        idle();
        check_val("preload_08", curr_score, 8'h08);
        drive(1'b1, 1'b0, 1'b0);
        check_val("held_inc_1", curr_score, 8'h09);
        check_digits("held_inc_1");
        drive(1'b1, 1'b0, 1'b0);
        check_val("held_inc_2", curr_score, 8'h10);
        check_digits("held_inc_2");
        drive(1'b1, 1'b0, 1'b0);
        check_val("held_inc_3", curr_score, 8'h11);
        check_digits("held_inc_3");
        idle();
        check_val("held_inc_stop", curr_score, 8'h11);

        // Borrow from 10 to 09
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check_val("borrow_09", curr_score, 8'h09);
        check_digits("borrow_09");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
